// File: rtl/fir_out_fifo.sv
// fir_out_fifo: output stage behind the FIR filter.
// Accepts FIR samples on a valid/ready stream. It can decimate by keeping
// 1 of every (decim+1) accepted beats, and it buffers the kept samples in a
// DEPTH-entry FIFO toward the chip-level consumer.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready   sample stream from the FIR
//   decim                  decimation select (keep 1 of decim+1)
//   clr_ovf                clears the sticky overflow flag
//   m_axis_tdata/tvalid/tready   head-of-FIFO stream to the consumer
//   level                  number of stored entries (0..DEPTH)
//   ovf                    sticky: a sample was offered while the FIFO was full
module fir_out_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [1:0]    decim,
    input  logic          clr_ovf,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [LW-1:0] level,
    output logic          ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic [1:0]    dcnt;

    logic full;
    logic empty;
    logic accept;
    logic wr_en;
    logic pop;

    assign full   = (count == LW'(DEPTH));
    assign empty  = (count == '0);
    assign accept = s_axis_tvalid && !full;
    // Only the first beat of each decimation group reaches the FIFO.
    assign wr_en  = accept && (dcnt == 2'd0);
    assign pop    = !empty && m_axis_tready;

    // tready depends on registered state only, never on m_axis_tready.
    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty;
    assign level         = count;
    // The memory is not cleared, so stale contents are masked while empty.
    assign m_axis_tdata  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dcnt   <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end

            // Using >= (not ==) makes a lowered decim wrap dcnt on the next accept.
            if (accept) begin
                if (dcnt >= decim) begin
                    dcnt <= 2'd0;
                end else begin
                    dcnt <= dcnt + 2'd1;
                end
            end

            // A set in the same cycle as a clear wins.
            if (s_axis_tvalid && full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_fifo.sv
module tb_fir_out_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [1:0] decim;
    logic       clr_ovf;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [2:0] level;
    logic       ovf;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    fir_out_fifo #(.DEPTH(4), .DW(8), .LW(3)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .decim(decim), .clr_ovf(clr_ovf),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .level(level), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever valid&&ready is seen here.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0h expected none", m_axis_tdata);
            end else begin
                chk("out_data", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Holds the beat until an edge with tready high; returns cycles waited.
    task automatic send(input logic [7:0] d, output int waited);
        logic rdy;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = s_axis_tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
        end
        if (waited >= 50) chk("send_timeout", 32'd1, 32'd0);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int first_try;
        logic [7:0] v2 [3];
        reset = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        decim = 2'd0;
        clr_ovf = 1'b0;
        m_axis_tready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset / idle state
        chk("rst_level", level, 3'd0);
        chk("rst_mvalid", m_axis_tvalid, 1'b0);
        chk("rst_sready", s_axis_tready, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_mdata", m_axis_tdata, 8'h00);

        // Pass-through, zero extra latency
        v2[0] = 8'h05; v2[1] = 8'hFB; v2[2] = 8'h7F;
        m_axis_tready = 1'b1;
        decim = 2'd0;
        for (int i = 0; i < 3; i++) exp_q.push_back(v2[i]);
        for (int i = 0; i < 3; i++) begin
            send(v2[i], w);
            chk("pt_mvalid", m_axis_tvalid, 1'b1);
            chk("pt_mdata", m_axis_tdata, v2[i]);
            chk("pt_level", level, 3'd1);
        end
        wait_drain();

        // Decimate by 4: keep 0, 4, 8
        decim = 2'd3;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd8);
        first_try = 0;
        for (int i = 0; i < 12; i++) begin
            send(8'(i), w);
            if (w == 0) first_try++;
        end
        chk("dec_all_ready", first_try, 32'd12);
        wait_drain();

        // Lowering decim below dcnt wraps dcnt on the next accept
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd44);
        send(8'd40, w);
        send(8'd41, w);
        send(8'd42, w);
        decim = 2'd1;
        send(8'd43, w);
        send(8'd44, w);
        wait_drain();
        do_reset();

        // Fill, overflow, full-with-pop, ovf clear behaviour
        decim = 2'd0;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send(8'(i), w);
        s_axis_tdata  = 8'd5;
        s_axis_tvalid = 1'b1;
        step();
        step();
        chk("full_level", level, 3'd4);
        chk("full_sready", s_axis_tready, 1'b0);
        chk("full_ovf", ovf, 1'b1);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        chk("fullpop_level", level, 3'd3);
        chk("fullpop_sready", s_axis_tready, 1'b1);
        step();
        chk("refill_level", level, 3'd4);
        s_axis_tvalid = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", ovf, 1'b0);
        s_axis_tdata  = 8'd6;
        s_axis_tvalid = 1'b1;
        clr_ovf = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        clr_ovf = 1'b0;
        chk("set_wins_ovf", ovf, 1'b1);
        chk("set_wins_level", level, 3'd4);
        m_axis_tready = 1'b1;
        wait_drain();

        // Reset mid-stream discards data and realigns decimation
        m_axis_tready = 1'b0;
        decim = 2'd1;
        for (int i = 20; i <= 24; i++) send(8'(i), w);
        chk("pre_rst_level", level, 3'd3);
        do_reset();
        chk("mid_rst_level", level, 3'd0);
        chk("mid_rst_mvalid", m_axis_tvalid, 1'b0);
        chk("mid_rst_mdata", m_axis_tdata, 8'h00);
        chk("mid_rst_ovf", ovf, 1'b0);
        exp_q.push_back(8'd30);
        send(8'd30, w);
        chk("post_rst_level", level, 3'd1);
        chk("post_rst_mdata", m_axis_tdata, 8'd30);
        m_axis_tready = 1'b1;
        wait_drain();
        step();
        chk("final_level", level, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
